// File: rtl/i2c_pkg.sv
//------------------------------------------------------------------------------
// Module  : i2c_pkg
// Brief   : Shared I2C types, constants and bus-drive helpers.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package i2c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BYTE  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  typedef logic [1:0] quarter_t;

  localparam logic       I2C_WRITE_BIT          = 1'b0;
  localparam logic [6:0] I2C_DEFAULT_SLAVE_ADDR = 7'h42;
  localparam logic [3:0] I2C_ACK_BIT            = 4'd8;

  // 1 = pull SCL low for the given phase position
  function automatic logic scl_pull(input state_t st, input quarter_t q);
    case (st)
      ST_START: scl_pull = (q == 2'd3);
      ST_BYTE:  scl_pull = !q[1];
      ST_STOP:  scl_pull = (q == 2'd0);
      default:  scl_pull = 1'b0;
    endcase
  endfunction

  function automatic logic sda_pull(input state_t st, input quarter_t q,
                                    input logic ack_bit, input logic data_bit);
    case (st)
      ST_START: sda_pull = (q != 2'd0);
      ST_BYTE:  sda_pull = !ack_bit && !data_bit;
      ST_STOP:  sda_pull = !q[1];
      default:  sda_pull = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_quarter_tick.sv
//------------------------------------------------------------------------------
// Module  : i2c_quarter_tick
// Brief   : SCL quarter-period divider; emits a tick and a 2-bit quarter index.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module i2c_quarter_tick
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_en,
  output logic     o_tick,
  output quarter_t o_quarter
);

  localparam int                 c_CNT_W   = $clog2(CLK_DIV);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLK_DIV - 1);

  logic [c_CNT_W-1:0] r_cnt;
  quarter_t           r_quarter;

  assign o_tick    = i_en && (r_cnt == c_CNT_MAX);
  assign o_quarter = r_quarter;

  // Held at zero while disabled so every frame starts on a fresh q0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_quarter <= '0;
    end else if (!i_en) begin
      r_cnt     <= '0;
      r_quarter <= '0;
    end else if (r_cnt == c_CNT_MAX) begin
      r_cnt     <= '0;
      r_quarter <= r_quarter + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2c_master_tx.sv
//------------------------------------------------------------------------------
// Module  : i2c_master_tx
// Brief   : I2C write master: START, addr+W, cmd byte, data byte, STOP.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module i2c_master_tx
  import i2c_pkg::*;
#(
  parameter int         CLK_DIV    = 4,
  parameter logic [6:0] SLAVE_ADDR = I2C_DEFAULT_SLAVE_ADDR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_cmd,
  input  logic [7:0] in_data,
  input  logic       in_rts,
  output logic       in_rtr,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       out_done,
  output logic       out_nack
);

  state_t     r_state;
  logic [7:0] r_cmd;
  logic [7:0] r_data;
  logic [7:0] r_shift;
  logic [3:0] r_bit_cnt;
  logic [1:0] r_byte_idx;
  logic       r_nack;
  logic       r_sda_dly;
  logic       r_sda_meta;
  logic       r_sda_s;

  logic       w_tick;
  quarter_t   w_quarter;
  logic       w_phase_end;
  logic       w_scl_pull;
  logic       w_sda_pull;

  i2c_quarter_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_quarter_tick (
    .clk       (clk),
    .rst       (rst),
    .i_en      (r_state != ST_IDLE),
    .o_tick    (w_tick),
    .o_quarter (w_quarter)
  );

  assign w_phase_end = w_tick && (w_quarter == 2'd3);
  assign w_scl_pull  = scl_pull(r_state, w_quarter);
  assign w_sda_pull  = sda_pull(r_state, w_quarter,
                                (r_bit_cnt == I2C_ACK_BIT), r_shift[7]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sda_meta <= 1'b1;
      r_sda_s    <= 1'b1;
    end else begin
      r_sda_meta <= sda_in;
      r_sda_s    <= r_sda_meta;
    end
  end

  // SCL follows the phase one cycle late and SDA two cycles late, so the two
  // pins never move on the same edge and SDA always settles after SCL falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cmd      <= '0;
      r_data     <= '0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_byte_idx <= '0;
      r_nack     <= 1'b0;
      r_sda_dly  <= 1'b0;
      in_rtr     <= 1'b1;
      scl_oe     <= 1'b0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      out_done   <= 1'b0;
      out_nack   <= 1'b0;
    end else begin
      out_done  <= 1'b0;
      out_nack  <= 1'b0;
      scl_oe    <= w_scl_pull;
      r_sda_dly <= w_sda_pull;
      sda_oe    <= r_sda_dly;

      case (r_state)
        ST_IDLE: begin
          if (in_rts && in_rtr) begin
            r_cmd      <= in_cmd;
            r_data     <= in_data;
            r_nack     <= 1'b0;
            r_bit_cnt  <= '0;
            r_byte_idx <= '0;
            in_rtr     <= 1'b0;
            busy       <= 1'b1;
            r_state    <= ST_START;
          end
        end

        ST_START: begin
          if (w_phase_end) begin
            r_shift   <= {SLAVE_ADDR, I2C_WRITE_BIT};
            r_bit_cnt <= '0;
            r_state   <= ST_BYTE;
          end
        end

        ST_BYTE: begin
          if (w_phase_end) begin
            if (r_bit_cnt != I2C_ACK_BIT) begin
              r_shift   <= {r_shift[6:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else begin
              r_bit_cnt <= '0;
              if (r_sda_s) begin
                r_nack  <= 1'b1;
                r_state <= ST_STOP;
              end else if (r_byte_idx == 2'd2) begin
                r_state <= ST_STOP;
              end else begin
                r_byte_idx <= r_byte_idx + 2'd1;
                r_shift    <= (r_byte_idx == 2'd0) ? r_cmd : r_data;
              end
            end
          end
        end

        ST_STOP: begin
          if (w_phase_end) begin
            out_done <= 1'b1;
            out_nack <= r_nack;
            in_rtr   <= 1'b1;
            busy     <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_master_tx.sv
//------------------------------------------------------------------------------
// Module  : tb_i2c_master_tx
// Brief   : Directed bench with open-drain bus model and behavioural slave.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_i2c_master_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_cmd = 8'h00;
  logic [7:0] in_data = 8'h00;
  logic       in_rts = 1'b0;
  wire        in_rtr, scl_oe, sda_oe, busy, out_done, out_nack;

  logic slv_oe = 1'b0;
  wire  scl_bus = ~scl_oe;
  wire  sda_bus = ~(sda_oe | slv_oe);

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  i2c_master_tx #(
    .CLK_DIV    (4),
    .SLAVE_ADDR (7'h42)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_cmd   (in_cmd),
    .in_data  (in_data),
    .in_rts   (in_rts),
    .in_rtr   (in_rtr),
    .sda_in   (sda_bus),
    .scl_oe   (scl_oe),
    .sda_oe   (sda_oe),
    .busy     (busy),
    .out_done (out_done),
    .out_nack (out_nack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural slave plus bus protocol monitor
  logic       slv_clr = 1'b0;
  int         nack_at = -1;
  logic [7:0] sh = 8'h00;
  int         bcnt = 0;
  logic       ack_ph = 1'b0;
  int         nbytes = 0;
  logic [7:0] dec [0:7];
  int         n_start = 0, n_stop = 0, n_rise = 0, n_same = 0;
  logic       p_scl = 1'b1, p_sda = 1'b1, p_scloe = 1'b0, p_sdaoe = 1'b0;

  always @(negedge clk) begin
    if (slv_clr) begin
      bcnt = 0; ack_ph = 1'b0; nbytes = 0; slv_oe = 1'b0;
      n_start = 0; n_stop = 0; n_rise = 0; n_same = 0;
    end else begin
      if (scl_oe !== p_scloe && sda_oe !== p_sdaoe) n_same++;
      if (p_scl && scl_bus && p_sda && !sda_bus) begin
        n_start++; bcnt = 0; ack_ph = 1'b0;
      end else if (p_scl && scl_bus && !p_sda && sda_bus) begin
        n_stop++; bcnt = 0; ack_ph = 1'b0;
      end else if (!p_scl && scl_bus) begin
        n_rise++;
        if (!ack_ph && bcnt < 8) begin
          sh = {sh[6:0], sda_bus};
          bcnt++;
          if (bcnt == 8) begin
            if (nbytes < 8) dec[nbytes] = sh;
            nbytes++;
          end
        end
      end else if (p_scl && !scl_bus) begin
        if (ack_ph) begin
          ack_ph = 1'b0; slv_oe = 1'b0; bcnt = 0;
        end else if (bcnt == 8) begin
          ack_ph = 1'b1;
          slv_oe = ((nbytes - 1) != nack_at);
        end
      end
    end
    p_scl = scl_bus; p_sda = sda_bus; p_scloe = scl_oe; p_sdaoe = sda_oe;
  end

  task automatic clear_monitor(input int nack_idx);
    nack_at = nack_idx;
    slv_clr = 1'b1;
    @(negedge clk);
    #1 slv_clr = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] c, input logic [7:0] d, output int acc);
    @(negedge clk);
    in_cmd = c; in_data = d; in_rts = 1'b1;
    @(posedge clk);
    #1 acc = cyc;
    @(negedge clk);
    in_rts = 1'b0;
  endtask

  task automatic wait_done(output int dcyc, output bit ok);
    ok = 1'b0; dcyc = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (out_done === 1'b1) begin
        ok = 1'b1; dcyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (in_rtr !== 1'b1) begin errors++; $display("FAIL reset_rtr: got %b want 1", in_rtr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (scl_oe !== 1'b0) begin errors++; $display("FAIL reset_scl_oe: got %b want 0", scl_oe); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
    checks++; if (out_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", out_done); end
    checks++; if (out_nack !== 1'b0) begin errors++; $display("FAIL reset_nack: got %b want 0", out_nack); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (in_rtr !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: rtr %b busy %b want 1 0", in_rtr, busy); end
  endtask

  task automatic test_reset_midframe;
    int  acc;
    bit  seen;
    bit  done_seen;
    clear_monitor(-1);
    send_pair(8'h12, 8'h34, acc);
    repeat (60) @(negedge clk);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (scl_oe === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL midframe_scl_low: got no SCL pull want one"); end
    #2 rst = 1'b1;
    #1;
    checks++; if (scl_oe !== 1'b0) begin errors++; $display("FAIL async_scl_release: got %b want 0", scl_oe); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL async_sda_release: got %b want 0", sda_oe); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (in_rtr !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: rtr %b busy %b want 1 0", in_rtr, busy); end
    done_seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (out_done === 1'b1) done_seen = 1'b1;
    end
    checks++; if (done_seen) begin errors++; $display("FAIL no_done_after_reset: got done want none"); end
  endtask

  task automatic test_single;
    int acc, dc;
    bit ok;
    logic [7:0] exp [0:2];
    exp[0] = 8'h84; exp[1] = 8'hA5; exp[2] = 8'h3C;
    clear_monitor(-1);
    send_pair(8'hA5, 8'h3C, acc);
    checks++; if (busy !== 1'b1 || in_rtr !== 1'b0) begin errors++; $display("FAIL single_accept: busy %b rtr %b want 1 0", busy, in_rtr); end
    wait_done(dc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_done_timeout: got none want out_done"); end
    checks++; if (dc - acc != 464) begin errors++; $display("FAIL single_latency: got %0d want 464", dc - acc); end
    checks++; if (out_nack !== 1'b0) begin errors++; $display("FAIL single_nack: got %b want 0", out_nack); end
    checks++; if (in_rtr !== 1'b1) begin errors++; $display("FAIL single_rtr_at_done: got %b want 1", in_rtr); end
    checks++; if (nbytes != 3) begin errors++; $display("FAIL single_nbytes: got %0d want 3", nbytes); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (dec[i] !== exp[i]) begin errors++; $display("FAIL single_byte%0d: got %h want %h", i, dec[i], exp[i]); end
    end
    checks++; if (n_start != 1 || n_stop != 1) begin errors++; $display("FAIL single_start_stop: got %0d/%0d want 1/1", n_start, n_stop); end
    checks++; if (n_rise != 28) begin errors++; $display("FAIL single_scl_rises: got %0d want 28", n_rise); end
    checks++; if (n_same != 0) begin errors++; $display("FAIL single_same_edge: got %0d want 0", n_same); end
    @(negedge clk);
    checks++; if (out_done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b want 0", out_done); end
  endtask

  task automatic test_nack;
    int acc, dc;
    bit ok;
    clear_monitor(0);
    send_pair(8'hFF, 8'h00, acc);
    wait_done(dc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL nack_done_timeout: got none want out_done"); end
    checks++; if (dc - acc != 176) begin errors++; $display("FAIL nack_latency: got %0d want 176", dc - acc); end
    checks++; if (out_nack !== 1'b1) begin errors++; $display("FAIL nack_flag: got %b want 1", out_nack); end
    checks++; if (nbytes != 1 || dec[0] !== 8'h84) begin errors++; $display("FAIL nack_bytes: got %0d/%h want 1/84", nbytes, dec[0]); end
    checks++; if (n_rise != 10) begin errors++; $display("FAIL nack_scl_rises: got %0d want 10", n_rise); end
    checks++; if (n_start != 1 || n_stop != 1) begin errors++; $display("FAIL nack_start_stop: got %0d/%0d want 1/1", n_start, n_stop); end
    checks++; if (n_same != 0) begin errors++; $display("FAIL nack_same_edge: got %0d want 0", n_same); end
  endtask

  task automatic test_back_to_back;
    int a1, a2, d1, d2;
    bit ok;
    logic [7:0] exp [0:5];
    exp[0] = 8'h84; exp[1] = 8'h11; exp[2] = 8'hF0;
    exp[3] = 8'h84; exp[4] = 8'h00; exp[5] = 8'hFF;
    clear_monitor(-1);
    @(negedge clk);
    in_cmd = 8'h11; in_data = 8'hF0; in_rts = 1'b1;
    @(posedge clk);
    #1 a1 = cyc;
    @(negedge clk);
    in_cmd = 8'h00; in_data = 8'hFF;
    wait_done(d1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_first_timeout: got none want out_done"); end
    checks++; if (d1 - a1 != 464) begin errors++; $display("FAIL b2b_first_latency: got %0d want 464", d1 - a1); end
    checks++; if (in_rtr !== 1'b1) begin errors++; $display("FAIL b2b_rtr_at_done: got %b want 1", in_rtr); end
    @(posedge clk);
    #1 a2 = cyc;
    checks++; if (busy !== 1'b1 || in_rtr !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: busy %b rtr %b want 1 0", busy, in_rtr); end
    checks++; if (a2 - d1 != 1) begin errors++; $display("FAIL b2b_accept_cycle: got %0d want 1", a2 - d1); end
    @(negedge clk);
    in_rts = 1'b0;
    wait_done(d2, ok);
    checks++; if (!ok || d2 - a2 != 464) begin errors++; $display("FAIL b2b_second_latency: got %0d want 464", d2 - a2); end
    checks++; if (nbytes != 6) begin errors++; $display("FAIL b2b_nbytes: got %0d want 6", nbytes); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (dec[i] !== exp[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h want %h", i, dec[i], exp[i]); end
    end
    checks++; if (n_start != 2 || n_stop != 2) begin errors++; $display("FAIL b2b_start_stop: got %0d/%0d want 2/2", n_start, n_stop); end
    checks++; if (n_same != 0) begin errors++; $display("FAIL b2b_same_edge: got %0d want 0", n_same); end
  endtask

  task automatic test_busy_rts;
    int acc, dc, rtr_hi;
    bit ok;
    clear_monitor(-1);
    send_pair(8'h5A, 8'hC3, acc);
    rtr_hi = 0;
    in_rts = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      in_cmd  = 8'(i * 37);
      in_data = ~8'(i * 11);
      if (in_rtr !== 1'b0) rtr_hi++;
    end
    in_rts = 1'b0;
    wait_done(dc, ok);
    checks++; if (rtr_hi != 0) begin errors++; $display("FAIL busy_rtr: got %0d high cycles want 0", rtr_hi); end
    checks++; if (!ok || dc - acc != 464) begin errors++; $display("FAIL busy_latency: got %0d want 464", dc - acc); end
    checks++; if (nbytes != 3 || dec[1] !== 8'h5A || dec[2] !== 8'hC3) begin
      errors++; $display("FAIL busy_latched: got %0d %h %h want 3 5a c3", nbytes, dec[1], dec[2]);
    end
  endtask

  initial begin
    test_reset();
    test_reset_midframe();
    test_single();
    test_nack();
    test_back_to_back();
    test_busy_rts();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
